cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Two-requester front end for the set-associative write-back cache. It arbitrates round-robin between requester 0 (instruction side) and requester 1 (data side), and sequences each granted access through the cache's combinational lookup and clock-edge update. On a read miss it re-reads the refilled line, then returns a single-cycle response to the owning requester. It also keeps saturating hit and miss counters for performance monitoring.

## Interface
Parameters:
- ADDR_WIDTH, 32, request/cache address width
- DATA_WIDTH, 32, data width
- STAT_WIDTH, 16, width of hit/miss counters

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit n = requester n
- req_ready  out  2  per-requester accept strobe (combinational)
- req_is_write  in  2  per-requester write flag
- req_addr  in  2*ADDR_WIDTH  per-requester address; requester n in slice [n*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  per-requester write data, sliced as above
- resp_valid  out  2  one-cycle response strobe to the owning requester
- resp_hit  out  1  response was a cache hit
- resp_data  out  DATA_WIDTH  read data (write data echoed for writes)
- cache_req  out  1  cache update enable; the cache updates its state only when high
- cache_address  out  ADDR_WIDTH  to cache `address`
- cache_is_write  out  1  to cache `is_write`
- cache_write_data  out  DATA_WIDTH  to cache `write_data`
- cache_hit  in  1  from cache `hit` (combinational)
- cache_read_data  in  DATA_WIDTH  from cache `read_data` (combinational)
- hit_count  out  STAT_WIDTH  saturating hit counter
- miss_count  out  STAT_WIDTH  saturating miss counter

## Operation
States: IDLE, LOOKUP, REREAD.

**IDLE**
- Grant rule: if exactly one req_valid bit is high, grant that requester. If both are high, grant the requester opposite last_grant.
- In the same cycle, assert req_ready[grant] and capture owner, is_write, addr and wdata into a request register.
- Update last_grant to the granted requester. Go to LOOKUP.
- If no request is valid, stay in IDLE; req_ready = 0.

**LOOKUP**
- Drive cache_req=1, cache_address/is_write/write_data from the request register.
- Sample cache_hit and cache_read_data before the edge.
- If cache_hit, or if the request is a write:
  - resp_valid[owner] <= 1.
  - resp_hit <= cache_hit.
  - resp_data <= (write ? wdata : cache_read_data).
  - Increment hit_count or miss_count according to cache_hit.
  - Go to IDLE.
- On a read miss: increment miss_count, go to REREAD. The cache refills the line at this edge.

**REREAD**
- cache_req=0; cache_address is still driven so the combinational hit path shows the refilled line.
- resp_valid[owner] <= 1, resp_hit <= 0, resp_data <= cache_read_data.
- Go to IDLE.

**Rules**
- Requesters hold req_valid and their request fields stable until req_ready.
- Responses have no backpressure.
- Counters saturate at 2^STAT_WIDTH-1; they do not wrap.
- cache_req is 0 in IDLE and REREAD, so the cache's frequency and FIFO state are touched exactly once per request.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first contention).
  - req_ready=0, resp_valid=0, resp_hit=0, resp_data=0.
  - cache_req=0, cache_address=0, cache_is_write=0, cache_write_data=0.
  - hit_count=0, miss_count=0.
- Latency, counted from the accept cycle (req_ready high) = cycle 0:
  - Hit or write: resp_valid in cycle 2.
  - Read miss: resp_valid in cycle 3.
- Throughput:
  - Hits and writes: one request per 2 cycles.
  - Read misses: one request per 3 cycles.
- A new accept can occur in the same cycle that resp_valid is high (state is IDLE).
- Reset asserted in any state:
  - The in-flight request is dropped with no response.
  - The FSM returns to IDLE on the next edge.
  - Counters clear.
- A write miss is handled as a single LOOKUP: the cache allocates with write_data, and the response carries resp_hit=0.

## Structure
- Shared package cache_pkg:
  - state typedef (IDLE, LOOKUP, REREAD).
  - Requester-id type (1 bit).
  - Shared ADDR_WIDTH/DATA_WIDTH defaults.
- Sub-module rr_arbiter_2:
  - Inputs: req[1:0], advance.
  - Outputs: one-hot grant and the last_grant register.
  - Instantiated once; advance = IDLE & any valid.
- Top level contains the FSM, request register, response register and counters.

## Test plan
- **Reset contention:** after reset, req_valid=2'b11 held -> req_ready=2'b01 first. After the response, req_ready=2'b10 next. Grants alternate thereafter.
- **Read hit:** pre-warm address 0x0000_0040 with a write of 0xDEADBEEF. Then a requester-1 read of 0x40 -> resp_valid[1] at cycle 2, resp_hit=1, resp_data=0xDEADBEEF, hit_count+1.
- **Read miss:** a read of an unseen address -> cache_req high for exactly one cycle, resp_valid at cycle 3 with resp_hit=0 and resp_data = the cache's refilled word, miss_count+1. A repeat read of the same address -> hit.
- **Write miss then read:** write 0x12345678 to 0x80 (miss, resp_hit=0, resp_data=0x12345678). Then read 0x80 -> hit, 0x12345678.
- **Reset mid-operation:** assert reset during REREAD -> no resp_valid, all outputs 0 on the next cycle, counters 0. A subsequent request completes normally.
- **Counter saturation:** with STAT_WIDTH=2, issue 5 hits -> hit_count stays at 3.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and defaults for the cache port arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int STAT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REREAD = 2'd2
    } state_t;

    typedef logic req_id_t;

    function automatic logic [1:0] req_onehot(input req_id_t id);
        return {id, ~id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_port_arbiter_if
// Description : Two-requester request/response bundle of the cache front end.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_port_arbiter_if
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [1:0]              req_is_write;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*DATA_WIDTH-1:0] req_wdata;
    logic [1:0]              resp_valid;
    logic                    resp_hit;
    logic [DATA_WIDTH-1:0]   resp_data;

    // Requesters drive the request fields; the arbiter owns ready and responses.
    modport master (
        output req_valid, req_is_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_hit, resp_data
    );

    modport slave (
        input  req_valid, req_is_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_hit, resp_data
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin arbiter with registered last grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output req_id_t    last_grant
);

    req_id_t w_pick;
    req_id_t r_last;

    always_comb begin
        w_pick = 1'b0;
        case (req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = ~r_last;
            default: w_pick = 1'b0;
        endcase
    end

    assign grant      = advance ? req_onehot(w_pick) : 2'b00;
    assign last_grant = r_last;

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (advance) begin
            r_last <= w_pick;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_port_arbiter
// Description : Round-robin front end sequencing requests through the cache.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STAT_WIDTH = STAT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    cache_port_arbiter_if.slave   req_if,
    output logic                  cache_req,
    output logic [ADDR_WIDTH-1:0] cache_address,
    output logic                  cache_is_write,
    output logic [DATA_WIDTH-1:0] cache_write_data,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_read_data,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
);

    state_t                r_state;
    state_t                w_next;
    logic                  w_advance;
    logic                  w_lookup;
    logic [1:0]            w_grant;
    req_id_t               w_last_grant;
    logic                  r_is_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_resp_valid;
    logic                  r_resp_hit;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic [STAT_WIDTH-1:0] r_hit_count;
    logic [STAT_WIDTH-1:0] r_miss_count;

    assign w_advance = (r_state == IDLE) && (|req_if.req_valid);
    assign w_lookup  = (r_state == LOOKUP);

    // last_grant only moves on an accept, so it names the in-flight owner.
    rr_arbiter_2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req_if.req_valid),
        .advance    (w_advance),
        .grant      (w_grant),
        .last_grant (w_last_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_advance) w_next = LOOKUP;
            LOOKUP:  w_next = (cache_hit || r_is_write) ? IDLE : REREAD;
            REREAD:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_write   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_data  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_resp_valid <= '0;
            if (w_advance) begin
                r_is_write <= w_grant[1] ? req_if.req_is_write[1] : req_if.req_is_write[0];
                r_addr     <= w_grant[1] ? req_if.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                         : req_if.req_addr[ADDR_WIDTH-1:0];
                r_wdata    <= w_grant[1] ? req_if.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : req_if.req_wdata[DATA_WIDTH-1:0];
            end
            if (w_lookup) begin
                if (cache_hit) begin
                    if (r_hit_count != '1) r_hit_count <= r_hit_count + STAT_WIDTH'(1);
                end else begin
                    if (r_miss_count != '1) r_miss_count <= r_miss_count + STAT_WIDTH'(1);
                end
                if (cache_hit || r_is_write) begin
                    r_resp_valid <= req_onehot(w_last_grant);
                    r_resp_hit   <= cache_hit;
                    r_resp_data  <= r_is_write ? r_wdata : cache_read_data;
                end
            end
            // The refill landed on the LOOKUP edge; the hit path now shows the line.
            if (r_state == REREAD) begin
                r_resp_valid <= req_onehot(w_last_grant);
                r_resp_hit   <= 1'b0;
                r_resp_data  <= cache_read_data;
            end
        end
    end

    assign req_if.req_ready  = w_grant;
    assign req_if.resp_valid = r_resp_valid;
    assign req_if.resp_hit   = r_resp_hit;
    assign req_if.resp_data  = r_resp_data;

    assign cache_req        = w_lookup;
    assign cache_address    = r_addr;
    assign cache_is_write   = r_is_write & w_lookup;
    assign cache_write_data = r_wdata;
    assign hit_count        = r_hit_count;
    assign miss_count       = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_port_arbiter
// Description : Directed bench with a small behavioural cache behind the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_port_arbiter;
    import cache_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 16;
    localparam logic [DW-1:0] REFILL_KEY = 32'hA5A5_5A5A;

    typedef struct {
        int          who;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_hit;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    cache_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    cache_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    assign bus2.req_valid    = bus.req_valid;
    assign bus2.req_is_write = bus.req_is_write;
    assign bus2.req_addr     = bus.req_addr;
    assign bus2.req_wdata    = bus.req_wdata;

    logic          cache_req, cache_is_write, cache_hit;
    logic [AW-1:0] cache_address;
    logic [DW-1:0] cache_write_data, cache_read_data;
    logic [SW-1:0] hit_count, miss_count;
    logic          c2_req, c2_is_write;
    logic [AW-1:0] c2_address;
    logic [DW-1:0] c2_write_data;
    logic [1:0]    hit2, miss2;

    cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STAT_WIDTH(SW)) dut (
        .clk(clk), .reset(rst), .req_if(bus),
        .cache_req(cache_req), .cache_address(cache_address),
        .cache_is_write(cache_is_write), .cache_write_data(cache_write_data),
        .cache_hit(cache_hit), .cache_read_data(cache_read_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Narrow-counter twin fed the same traffic, for saturation.
    cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STAT_WIDTH(2)) dut2 (
        .clk(clk), .reset(rst), .req_if(bus2),
        .cache_req(c2_req), .cache_address(c2_address),
        .cache_is_write(c2_is_write), .cache_write_data(c2_write_data),
        .cache_hit(cache_hit), .cache_read_data(cache_read_data),
        .hit_count(hit2), .miss_count(miss2)
    );

    // Behavioural cache: allocate on any miss; read misses refill addr^KEY.
    logic          m_valid [8];
    logic [AW-1:0] m_addr  [8];
    logic [DW-1:0] m_data  [8];
    int            m_next;
    int            m_idx;
    logic          model_clr;

    always_comb begin
        cache_hit       = 1'b0;
        cache_read_data = '0;
        m_idx           = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_addr[i] == cache_address) begin
                cache_hit       = 1'b1;
                cache_read_data = m_data[i];
                m_idx           = i;
            end
        end
    end

    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 8; i++) m_valid[i] <= 1'b0;
            m_next <= 0;
        end else if (cache_req) begin
            if (cache_hit) begin
                if (cache_is_write) m_data[m_idx] <= cache_write_data;
            end else begin
                m_valid[m_next] <= 1'b1;
                m_addr[m_next]  <= cache_address;
                m_data[m_next]  <= cache_is_write ? cache_write_data : (cache_address ^ REFILL_KEY);
                m_next          <= (m_next + 1) % 8;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int who, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid[who]    = 1'b1;
        bus.req_is_write[who] = wr;
        if (who == 0) begin
            bus.req_addr[31:0]  = a;
            bus.req_wdata[31:0] = d;
        end else begin
            bus.req_addr[63:32]  = a;
            bus.req_wdata[63:32] = d;
        end
    endtask

    task automatic run_req(input vec_t v);
        int lat;
        int pulses;
        bit got;
        tick();
        set_req(v.who, v.wr, v.addr, v.wdata);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready[v.who]) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_seen", 64'(got), 64'd1);
        if (!got) begin
            bus.req_valid = '0;
            return;
        end
        check("ready_onehot", 64'(bus.req_ready), 64'(req_onehot(req_id_t'(v.who))));
        tick();
        bus.req_valid[v.who] = 1'b0;
        lat    = 1;
        pulses = 0;
        got    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b00) begin
                got = 1'b1;
                break;
            end
            if (cache_req) pulses++;
            lat++;
        end
        check("resp_seen", 64'(got), 64'd1);
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("resp_owner", 64'(bus.resp_valid), 64'(req_onehot(req_id_t'(v.who))));
        check("resp_hit", 64'(bus.resp_hit), 64'(v.exp_hit));
        check("resp_data", 64'(bus.resp_data), 64'(v.exp_data));
        check("cache_req_pulses", 64'(pulses), 64'd1);
    endtask

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 1'b0, 32'h40,  32'h0,         1'b1, 32'hDEADBEEF, 2};
        vecs[1] = '{0, 1'b0, 32'h100, 32'h0,         1'b0, 32'hA5A55B5A, 3};
        vecs[2] = '{0, 1'b0, 32'h100, 32'h0,         1'b1, 32'hA5A55B5A, 2};
        vecs[3] = '{1, 1'b1, 32'h80,  32'h12345678,  1'b0, 32'h12345678, 2};
        vecs[4] = '{0, 1'b0, 32'h80,  32'h0,         1'b1, 32'h12345678, 2};
        vecs[5] = '{1, 1'b1, 32'h40,  32'hCAFEF00D,  1'b1, 32'hCAFEF00D, 2};
        vecs[6] = '{0, 1'b0, 32'h40,  32'h0,         1'b1, 32'hCAFEF00D, 2};
        vecs[7] = '{1, 1'b0, 32'hC0,  32'h0,         1'b1, 32'h0BADF00D, 2};

        model_clr         = 1'b1;
        bus.req_valid     = '0;
        bus.req_is_write  = '0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        model_clr = 1'b0;

        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_hit", 64'(bus.resp_hit), 64'd0);
        check("rst_resp_data", 64'(bus.resp_data), 64'd0);
        check("rst_cache_req", 64'(cache_req), 64'd0);
        check("rst_cache_address", 64'(cache_address), 64'd0);
        check("rst_cache_is_write", 64'(cache_is_write), 64'd0);
        check("rst_cache_write_data", 64'(cache_write_data), 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_miss_count", 64'(miss_count), 64'd0);

        // Contention: requester 0 first, then alternation.
        tick();
        set_req(0, 1'b1, 32'h40, 32'hDEADBEEF);
        set_req(1, 1'b1, 32'hC0, 32'h0BADF00D);
        @(negedge clk);
        check("cont_first_grant", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("cont_lookup_ready", 64'(bus.req_ready), 64'h0);
        check("cont_lookup_cache_req", 64'(cache_req), 64'h1);
        tick();
        @(negedge clk);
        check("cont_resp0", 64'(bus.resp_valid), 64'h1);
        check("cont_resp0_hit", 64'(bus.resp_hit), 64'h0);
        check("cont_resp0_data", 64'(bus.resp_data), 64'hDEADBEEF);
        check("cont_second_grant", 64'(bus.req_ready), 64'h2);
        tick();
        set_req(0, 1'b1, 32'h44, 32'h44444444);
        set_req(1, 1'b1, 32'hC4, 32'h0C4C4C4C);
        @(negedge clk);
        check("cont_lookup2_ready", 64'(bus.req_ready), 64'h0);
        tick();
        @(negedge clk);
        check("cont_resp1", 64'(bus.resp_valid), 64'h2);
        check("cont_third_grant", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid[0] = 1'b0;
        tick();
        @(negedge clk);
        check("cont_resp0b", 64'(bus.resp_valid), 64'h1);
        check("cont_fourth_grant", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = '0;
        tick();
        @(negedge clk);
        check("cont_resp1b", 64'(bus.resp_valid), 64'h2);
        check("cont_miss_count", 64'(miss_count), 64'd4);
        check("cont_hit_count", 64'(hit_count), 64'd0);

        for (int i = 0; i < 8; i++) run_req(vecs[i]);

        @(negedge clk);
        check("tbl_hit_count", 64'(hit_count), 64'd6);
        check("tbl_miss_count", 64'(miss_count), 64'd6);
        check("sat_hit_count", 64'(hit2), 64'd3);
        check("sat_miss_count", 64'(miss2), 64'd3);

        // Reset while in REREAD drops the response and clears counters.
        tick();
        set_req(0, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        check("mid_accept", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("mid_lookup_cache_req", 64'(cache_req), 64'h1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_reread_cache_req", 64'(cache_req), 64'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_resp_valid", 64'(bus.resp_valid), 64'h0);
        check("mid_resp_data", 64'(bus.resp_data), 64'h0);
        check("mid_cache_address", 64'(cache_address), 64'h0);
        check("mid_hit_count", 64'(hit_count), 64'h0);
        check("mid_miss_count", 64'(miss_count), 64'h0);
        @(negedge clk);
        check("mid_no_late_resp", 64'(bus.resp_valid), 64'h0);

        run_req('{1, 1'b0, 32'h200, 32'h0, 1'b1, 32'hA5A5585A, 2});
        @(negedge clk);
        check("post_hit_count", 64'(hit_count), 64'd1);
        check("post_miss_count", 64'(miss_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
